// File: rtl/uart_message_tx_pkg.sv
// Shared types and helpers for the buffered UART message sender.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_GAP
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  function automatic int frame_cycles(input int clks_per_bit, input int data_bits,
                                      input int parity, input int stop_bits);
    return (1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_message_tx_if.sv
// Control, buffer-write and serial-output signals of the UART message sender.
interface uart_message_tx_if #(
  parameter int DATA_BITS = 8,
  parameter int MSG_LEN   = 16
);
  localparam int AW = $clog2(MSG_LEN);

  logic                 SW;
  logic                 start;
  logic [AW:0]          msg_len;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [DATA_BITS-1:0] wr_data;
  logic                 txd;
  logic [DATA_BITS-1:0] word;
  logic [AW:0]          counter;
  logic                 transmit_ready;
  logic                 msg_done;

  modport master (
    output SW, start, msg_len, wr_en, wr_addr, wr_data,
    input  txd, word, counter, transmit_ready, msg_done
  );

  modport slave (
    input  SW, start, msg_len, wr_en, wr_addr, wr_data,
    output txd, word, counter, transmit_ready, msg_done
  );
endinterface

// File: rtl/uart_message_tx_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);
  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (rst || restart || tick) cnt <= '0;
    else                        cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/uart_message_tx.sv
// Streams a message out of a writable character buffer as UART frames,
// one-shot or looping with an idle gap between repeats.
module uart_message_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int MSG_LEN      = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int GAP_CYCLES   = 64
) (
  input logic              clk,
  input logic              rst,
  uart_message_tx_if.slave bus
);
  localparam int AW = $clog2(MSG_LEN);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [AW:0]    LEN_MAX   = (AW+1)'(MSG_LEN);
  localparam logic [AW-1:0]  ADDR0     = '0;
  localparam logic [GW-1:0]  GAP_LOAD  = GW'(GAP_CYCLES - 1);
  localparam logic [BW-1:0]  BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic           STOP_LAST = 1'(STOP_BITS - 1);

  logic [DATA_BITS-1:0] mem [MSG_LEN];

  state_t               state;
  logic                 txd_q;
  logic [DATA_BITS-1:0] word_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [AW:0]          counter_q;
  logic [AW:0]          len_q;
  logic                 ready_q;
  logic                 done_q;
  logic [GW-1:0]        gap_cnt;
  logic                 stop_idx;
  logic [BW-1:0]        bit_idx;

  logic                 tick;
  logic                 baud_restart;
  logic                 len_ok;
  logic                 par_bit;
  logic [AW:0]          counter_inc;

  // Timer idles at zero outside bit states, so every bit state starts a fresh period.
  assign baud_restart = (state == ST_IDLE) || (state == ST_GAP);
  assign len_ok       = (bus.msg_len != '0) && (bus.msg_len <= LEN_MAX);
  assign par_bit      = (PARITY == PAR_ODD) ? ~^word_q : ^word_q;
  assign counter_inc  = counter_q + 1'b1;

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (baud_restart),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      txd_q     <= 1'b1;
      word_q    <= '0;
      shift_q   <= '0;
      counter_q <= '0;
      len_q     <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      gap_cnt   <= '0;
      stop_idx  <= 1'b0;
      bit_idx   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start && len_ok) begin
            state     <= ST_START;
            counter_q <= '0;
            len_q     <= bus.msg_len;
            word_q    <= mem[ADDR0];
            ready_q   <= 1'b0;
            txd_q     <= 1'b0;
          end
        end
        ST_START: begin
          if (tick) begin
            state   <= ST_DATA;
            bit_idx <= '0;
            txd_q   <= word_q[0];
            shift_q <= word_q >> 1;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_idx == BIT_LAST) begin
              if (PARITY != PAR_NONE) begin
                state <= ST_PARITY;
                txd_q <= par_bit;
              end else begin
                state    <= ST_STOP;
                txd_q    <= 1'b1;
                stop_idx <= 1'b0;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              txd_q   <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            state    <= ST_STOP;
            txd_q    <= 1'b1;
            stop_idx <= 1'b0;
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (stop_idx != STOP_LAST) begin
              stop_idx <= 1'b1;
            end else if (counter_inc < len_q) begin
              // Next character follows immediately; the read sees pre-write data.
              state     <= ST_START;
              counter_q <= counter_inc;
              word_q    <= mem[counter_inc[AW-1:0]];
              txd_q     <= 1'b0;
            end else begin
              done_q <= 1'b1;
              if (bus.SW) begin
                state   <= ST_GAP;
                gap_cnt <= GAP_LOAD;
              end else begin
                state   <= ST_IDLE;
                ready_q <= 1'b1;
              end
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            if (bus.SW) begin
              state     <= ST_START;
              counter_q <= '0;
              word_q    <= mem[ADDR0];
              txd_q     <= 1'b0;
            end else begin
              state   <= ST_IDLE;
              ready_q <= 1'b1;
            end
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.txd            = txd_q;
  assign bus.word           = word_q;
  assign bus.counter        = counter_q;
  assign bus.transmit_ready = ready_q;
  assign bus.msg_done       = done_q;
endmodule
